// File: rtl/dosificador_pkg.sv
// Shared definitions for the colour dosing block: FSM encoding, channel
// indices and one-hot helpers used by the command decoder.
package dosificador_pkg;

  localparam int DOSE_W_DEF = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Channel index doubles as the bit position in Motores/step/flags.
  localparam logic [1:0] CH_R = 2'd2;
  localparam logic [1:0] CH_Y = 2'd1;
  localparam logic [1:0] CH_B = 2'd0;

  function automatic logic is_onehot(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
  endfunction

  function automatic logic is_multihot(input logic [2:0] m);
    return (m & (m - 3'd1)) != 3'd0;
  endfunction

  function automatic logic [1:0] oh_idx(input logic [2:0] m);
    logic [1:0] idx;
    case (m)
      3'b100:  idx = CH_R;
      3'b010:  idx = CH_Y;
      default: idx = CH_B;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] idx_oh(input logic [1:0] c);
    logic [2:0] oh;
    case (c)
      CH_R:    oh = 3'b100;
      CH_Y:    oh = 3'b010;
      CH_B:    oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dosificador_if.sv
// Command/status bundle between the colour command FSM (master) and the
// dosing block (slave).
interface dosificador_if
  import dosificador_pkg::*;
#(
  parameter int DOSE_W = DOSE_W_DEF
);
  logic [2:0]        Motores;
  logic [DOSE_W-1:0] dose_r;
  logic [DOSE_W-1:0] dose_y;
  logic [DOSE_W-1:0] dose_b;
  logic [2:0]        step;
  logic [2:0]        flags;
  logic              busy;
  logic              err;

  modport master (
    output Motores, dose_r, dose_y, dose_b,
    input  step, flags, busy, err
  );

  modport slave (
    input  Motores, dose_r, dose_y, dose_b,
    output step, flags, busy, err
  );
endinterface

// File: rtl/dosificador_gen_tick.sv
// Motor step prescaler: one-cycle tick every TICK_DIV clocks, held at zero
// while clear is high so the first tick lands TICK_DIV cycles after release.
module gen_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     cnt <= '0;
    else if (clear || cnt == LAST) cnt <= '0;
    else                           cnt <= cnt + CW'(1);
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/dosificador.sv
// Single-channel-at-a-time dosing sequencer: accepts a one-hot colour
// command, issues dose step pulses at the prescaler rate, then holds a flag.
module dosificador
  import dosificador_pkg::*;
#(
  parameter int DOSE_W   = DOSE_W_DEF,
  parameter int TICK_DIV = 50000
) (
  input logic           clk,
  input logic           reset,
  dosificador_if.slave  bus
);

  logic [1:0]        rst_sync;
  logic              rst_int;
  logic [1:0]        state, state_nxt;
  logic [1:0]        chan;
  logic [2:0]        ch_oh;
  logic [DOSE_W-1:0] cnt;
  logic [DOSE_W-1:0] dose_sel;
  logic [2:0]        step_q, flags_q;
  logic              err_q;
  logic              tick;
  logic              cmd_lost;
  logic              cmd_hold;

  // Assert asynchronously, release two edges after reset drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  gen_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (rst_int),
    .clear (state != S_RUN),
    .tick  (tick)
  );

  assign ch_oh    = idx_oh(chan);
  // Any departure from the latched one-hot command (drop or switch) aborts.
  assign cmd_lost = (bus.Motores != ch_oh);
  assign cmd_hold = |(bus.Motores & ch_oh);

  always_comb begin
    dose_sel = '0;
    case (bus.Motores)
      3'b100:  dose_sel = bus.dose_r;
      3'b010:  dose_sel = bus.dose_y;
      3'b001:  dose_sel = bus.dose_b;
      default: dose_sel = '0;
    endcase
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: state_nxt = is_onehot(bus.Motores) ? S_LOAD : S_IDLE;
      S_LOAD: begin
        if (cmd_lost)       state_nxt = S_IDLE;
        else if (cnt == '0) state_nxt = S_DONE;
        else                state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cmd_lost)       state_nxt = S_IDLE;
        else if (cnt == '0) state_nxt = S_DONE;
        else                state_nxt = S_RUN;
      end
      S_DONE:  state_nxt = cmd_hold ? S_DONE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state   <= S_IDLE;
      chan    <= '0;
      cnt     <= '0;
      step_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      step_q  <= '0;
      err_q   <= 1'b0;
      flags_q <= (state_nxt == S_DONE) ? ch_oh : 3'b000;
      case (state)
        S_IDLE: begin
          if (is_onehot(bus.Motores)) begin
            chan <= oh_idx(bus.Motores);
            cnt  <= dose_sel;
          end else if (is_multihot(bus.Motores)) begin
            err_q <= 1'b1;
          end
        end
        S_RUN: begin
          // Counter guard keeps the down-count from wrapping past zero.
          if (!cmd_lost && tick && cnt != '0) begin
            step_q <= ch_oh;
            cnt    <= cnt - DOSE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.step  = step_q;
  assign bus.flags = flags_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state == S_LOAD) || (state == S_RUN);

endmodule
